// File: rtl/i2s_receiver_pkg.sv
// i2s_receiver_pkg
// Shared constants, the receiver state type and a word-alignment helper for
// the I2S receiver.
//   I2S_DATA_W        : audio sample width (24)
//   I2S_SLOT_W        : sck periods per channel slot (32)
//   I2S_RX_FIFO_DEPTH : output FIFO depth in sample pairs (2)
package i2s_receiver_pkg;

    localparam int I2S_DATA_W        = 24;
    localparam int I2S_SLOT_W        = 32;
    localparam int I2S_RX_FIFO_DEPTH = 2;
    localparam int I2S_CNT_W         = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } i2s_state_e;

    // Left-justify a word of which only cnt bits (capped at 24) arrived;
    // the missing LSBs come out as zero.
    function automatic logic [I2S_DATA_W-1:0] i2s_align_word(
        input logic [I2S_DATA_W-1:0] shift,
        input logic [I2S_CNT_W-1:0]  cnt
    );
        logic [I2S_CNT_W-1:0] pad;
        if (cnt >= 5'd24) begin
            pad = 5'd0;
        end else begin
            pad = 5'd24 - cnt;
        end
        return shift << pad;
    endfunction

endpackage

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo
// Two-entry synchronous FIFO holding {left, right} sample pairs. Entry 0 is
// always the head, so the head output needs no read pointer.
//   clk, rst    : clock, synchronous active-high reset
//   flush_i     : empties the FIFO (takes priority over push/pop)
//   push_i      : write din_i; ignored when full unless popping the same cycle
//   pop_i       : remove head entry; ignored when empty
//   head_o      : current head entry
//   full_o      : two entries held
//   empty_o     : no entries held
module i2s_rx_fifo
    import i2s_receiver_pkg::*;
#(
    parameter int W = 2 * I2S_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_eff_s;
    logic         push_eff_s;
    logic [1:0]   wr_idx_s;

    // Next-state computation: pop shifts entry 1 to the head, push writes the
    // first free slot as seen after the pop.
    always_comb begin
        mem0_d     = mem0_q;
        mem1_d     = mem1_q;
        count_d    = count_q;
        pop_eff_s  = pop_i && (count_q != 2'd0);
        push_eff_s = push_i && ((count_q != 2'd2) || pop_eff_s);
        wr_idx_s   = count_q - {1'b0, pop_eff_s};
        if (flush_i) begin
            mem0_d  = '0;
            mem1_d  = '0;
            count_d = 2'd0;
        end else begin
            if (pop_eff_s) begin
                mem0_d = mem1_q;
            end else begin
                mem0_d = mem0_q;
            end
            if (push_eff_s) begin
                if (wr_idx_s == 2'd0) begin
                    mem0_d = din_i;
                end else begin
                    mem1_d = din_i;
                end
            end else begin
                mem1_d = mem1_q;
            end
            count_d = count_q - {1'b0, pop_eff_s} + {1'b0, push_eff_s};
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem0_q;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver
// Oversampling I2S receiver: synchronizes sck/ws/sdi into clk, decodes
// 32-sck slots with one-bit delay, MSB first, 24 data bits per channel, and
// queues {left, right} pairs in a 2-entry FIFO with a valid/ready output.
//   clk, rst               : clock, synchronous active-high reset
//   sck_in, ws_in, sdi_in  : asynchronous I2S bit clock, word select, data
//   enable_in              : receiver enable (0 flushes and idles)
//   clr_in                 : clears the sticky error flags
//   audio0_out, audio1_out : left / right sample of the FIFO head
//   valid_out, ready_in    : output handshake
//   overrun_out            : sticky, pair dropped on a full FIFO
//   frame_err_out          : sticky, slot length error
// Build option: I2S_RECEIVER_FRAMECHK_EN enables the slot length check;
// without it frame_err_out is 0 and short words are left-justified.
module i2s_receiver
    import i2s_receiver_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck_in,
    input  logic                  ws_in,
    input  logic                  sdi_in,
    input  logic                  enable_in,
    input  logic                  clr_in,
    output logic [I2S_DATA_W-1:0] audio0_out,
    output logic [I2S_DATA_W-1:0] audio1_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  overrun_out,
    output logic                  frame_err_out
);

    logic [2:0]            sck_sync_q;
    logic [1:0]            ws_sync_q;
    logic [1:0]            sdi_sync_q;
    logic                  ws_prev_q;
    i2s_state_e            state_q, state_d;
    logic [I2S_CNT_W-1:0]  cnt_q, cnt_d;
    logic [I2S_DATA_W-1:0] shift_q, shift_d;
    logic [I2S_DATA_W-1:0] left_q, left_d;
    logic                  overrun_q, overrun_d;

    logic                  sck_rise_s;
    logic                  change_s;
    logic [I2S_DATA_W-1:0] word_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  flush_s;
    logic                  full_s;
    logic                  empty_s;
    logic [2*I2S_DATA_W-1:0] head_s;

    assign sck_rise_s = sck_sync_q[1] & ~sck_sync_q[2];
    assign change_s   = sck_rise_s && (ws_sync_q[1] != ws_prev_q);
    assign word_s     = i2s_align_word(shift_q, cnt_q);

`ifdef I2S_RECEIVER_FRAMECHK_EN
    logic frame_err_q, frame_err_d;
    logic frame_err_set_s;
`endif

    // Slot decoding: edge counter, data shift register and channel FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        left_d  = left_q;
        push_s  = 1'b0;
        flush_s = 1'b0;
`ifdef I2S_RECEIVER_FRAMECHK_EN
        frame_err_set_s = 1'b0;
`endif
        if (!enable_in) begin
            state_d = IDLE;
            cnt_d   = 5'd0;
            shift_d = '0;
            flush_s = 1'b1;
        end else begin
            // The change edge itself carries the previous slot's last bit,
            // so it restarts the count without shifting.
            if (change_s) begin
                cnt_d   = 5'd0;
                shift_d = '0;
            end else if (sck_rise_s) begin
                if (cnt_q != 5'd31) begin
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                if (cnt_q < 5'd24) begin
                    shift_d = {shift_q[I2S_DATA_W-2:0], sdi_sync_q[1]};
                end else begin
                    shift_d = shift_q;
                end
            end else begin
                cnt_d   = cnt_q;
                shift_d = shift_q;
            end

            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                end
                SYNC: begin
                    if (change_s && !ws_sync_q[1]) begin
                        state_d = LEFT;
                    end else begin
                        state_d = SYNC;
                    end
                end
                LEFT: begin
                    if (change_s) begin
`ifdef I2S_RECEIVER_FRAMECHK_EN
                        if (cnt_q != 5'd31) begin
                            frame_err_set_s = 1'b1;
                            state_d         = SYNC;
                        end else begin
                            left_d  = word_s;
                            state_d = RIGHT;
                        end
                    end else if (sck_rise_s && (cnt_q == 5'd31)) begin
                        frame_err_set_s = 1'b1;
                        state_d         = SYNC;
`else
                        left_d  = word_s;
                        state_d = RIGHT;
`endif
                    end else begin
                        state_d = LEFT;
                    end
                end
                RIGHT: begin
                    if (change_s) begin
`ifdef I2S_RECEIVER_FRAMECHK_EN
                        if (cnt_q != 5'd31) begin
                            frame_err_set_s = 1'b1;
                            state_d         = SYNC;
                        end else begin
                            push_s  = 1'b1;
                            state_d = LEFT;
                        end
                    end else if (sck_rise_s && (cnt_q == 5'd31)) begin
                        frame_err_set_s = 1'b1;
                        state_d         = SYNC;
`else
                        push_s  = 1'b1;
                        state_d = LEFT;
`endif
                    end else begin
                        state_d = RIGHT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign pop_s = ~empty_s & ready_in;

    // Overrun: a push that finds the FIFO full with no pop alongside. A new
    // error wins over a coincident clear.
    always_comb begin
        if (push_s && full_s && !pop_s) begin
            overrun_d = 1'b1;
        end else if (clr_in) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Synchronizers, ws history, decoder state and sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q <= 3'd0;
            ws_sync_q  <= 2'd0;
            sdi_sync_q <= 2'd0;
            ws_prev_q  <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            shift_q    <= '0;
            left_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[1:0], sck_in};
            ws_sync_q  <= {ws_sync_q[0], ws_in};
            sdi_sync_q <= {sdi_sync_q[0], sdi_in};
            if (sck_rise_s) begin
                ws_prev_q <= ws_sync_q[1];
            end else begin
                ws_prev_q <= ws_prev_q;
            end
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            left_q     <= left_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef I2S_RECEIVER_FRAMECHK_EN
    // Frame error: set wins over a coincident clear.
    always_comb begin
        if (frame_err_set_s) begin
            frame_err_d = 1'b1;
        end else if (clr_in) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
    end

    // Frame error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err_out = frame_err_q;
`else
    assign frame_err_out = 1'b0;
`endif

    i2s_rx_fifo #(
        .W (2 * I2S_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_s),
        .push_i  (push_s),
        .din_i   ({left_q, word_s}),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign valid_out   = ~empty_s;
    assign audio0_out  = head_s[2*I2S_DATA_W-1:I2S_DATA_W];
    assign audio1_out  = head_s[I2S_DATA_W-1:0];
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver
// Directed bench for i2s_receiver: drives I2S frames (sck = 8 clk periods),
// records every valid/ready transfer and compares against hand-computed pairs.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck_in, ws_in, sdi_in;
    logic        enable_in, clr_in, ready_in;
    logic [23:0] audio0_out, audio1_out;
    logic        valid_out, overrun_out, frame_err_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [47:0] got[$];

    always #5 clk = ~clk;

    i2s_receiver dut (
        .clk           (clk),
        .rst           (rst),
        .sck_in        (sck_in),
        .ws_in         (ws_in),
        .sdi_in        (sdi_in),
        .enable_in     (enable_in),
        .clr_in        (clr_in),
        .audio0_out    (audio0_out),
        .audio1_out    (audio1_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .overrun_out   (overrun_out),
        .frame_err_out (frame_err_out)
    );

    // Record each pair that transfers on the coming rising edge.
    always begin
        @(negedge clk);
        #1;
        if (valid_out === 1'b1 && ready_in === 1'b1) begin
            got.push_back({audio0_out, audio1_out});
        end
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] got_at(input int i);
        if (i < got.size()) begin
            return got[i];
        end else begin
            return 48'hxxxx_xxxx_xxxx;
        end
    endfunction

    task automatic send_edge(input logic ws, input logic sd);
        sck_in = 1'b0;
        ws_in  = ws;
        sdi_in = sd;
        repeat (4) @(negedge clk);
        sck_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Same as send_edge, but ready_in is high only for the clk cycle in
    // which the receiver acts on this sck rise (third rising clk edge).
    task automatic send_edge_pop(input logic ws, input logic sd);
        sck_in = 1'b0;
        ws_in  = ws;
        sdi_in = sd;
        repeat (4) @(negedge clk);
        sck_in = 1'b1;
        repeat (2) @(negedge clk);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        @(negedge clk);
    endtask

    // Edge 0 is the change edge, edges 1..24 carry word[23..0], rest pad 0.
    task automatic send_slot(input logic ws, input logic [23:0] word, input int nedges);
        for (int k = 0; k < nedges; k++) begin
            if (k >= 1 && k <= 24) begin
                send_edge(ws, word[24-k]);
            end else begin
                send_edge(ws, 1'b0);
            end
        end
    endtask

    task automatic send_frame(input logic [47:0] pair);
        send_slot(1'b0, pair[47:24], 32);
        send_slot(1'b1, pair[23:0], 32);
    endtask

    // Re-enable the receiver and send a ws=1 slot so the next left slot
    // starts with a 1->0 change edge.
    task automatic start();
        @(negedge clk);
        enable_in = 1'b0;
        repeat (3) @(negedge clk);
        enable_in = 1'b1;
        send_slot(1'b1, 24'h000000, 32);
    endtask

    task automatic drain();
        ready_in = 1'b1;
        repeat (4) @(negedge clk);
        ready_in = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        sck_in    = 1'b0;
        ws_in     = 1'b0;
        sdi_in    = 1'b0;
        enable_in = 1'b0;
        clr_in    = 1'b0;
        ready_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {47'd0, valid_out}, 48'd0);
        check("rst_audio", {audio0_out, audio1_out}, 48'd0);
        check("rst_flags", {46'd0, overrun_out, frame_err_out}, 48'd0);
        rst = 1'b0;

        // Single frame with ready held high.
        got.delete();
        ready_in = 1'b1;
        start();
        send_frame({24'h123456, 24'hABCDEF});
        send_edge(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        ready_in = 1'b0;
        check("t1_count", 48'(got.size()), 48'd1);
        check("t1_pair", got_at(0), {24'h123456, 24'hABCDEF});
        check("t1_valid_after", {47'd0, valid_out}, 48'd0);
        check("t1_flags", {46'd0, overrun_out, frame_err_out}, 48'd0);

        // Three frames with no reader: two kept, third dropped.
        got.delete();
        start();
        send_frame({24'h800001, 24'h7FFFFE});
        send_frame({24'hA5A5A5, 24'h5A5A5A});
        send_frame({24'hFFFFFF, 24'h000000});
        send_edge(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("t2_valid", {47'd0, valid_out}, 48'd1);
        check("t2_head", {audio0_out, audio1_out}, {24'h800001, 24'h7FFFFE});
        check("t2_overrun", {47'd0, overrun_out}, 48'd1);
        clr_in = 1'b1;
        @(negedge clk);
        clr_in = 1'b0;
        check("t2_overrun_clr", {47'd0, overrun_out}, 48'd0);
        drain();
        check("t2_count", 48'(got.size()), 48'd2);
        check("t2_first", got_at(0), {24'h800001, 24'h7FFFFE});
        check("t2_second", got_at(1), {24'hA5A5A5, 24'h5A5A5A});
        check("t2_empty", {47'd0, valid_out}, 48'd0);

        // Push into a full FIFO while popping in the same cycle.
        got.delete();
        start();
        send_frame({24'h010203, 24'h040506});
        send_frame({24'h0A0B0C, 24'h0D0E0F});
        send_frame({24'hC0FFEE, 24'hBADF00});
        send_edge_pop(1'b0, 1'b0);
        check("t3_popped", got_at(0), {24'h010203, 24'h040506});
        check("t3_no_overrun", {47'd0, overrun_out}, 48'd0);
        check("t3_head", {audio0_out, audio1_out}, {24'h0A0B0C, 24'h0D0E0F});
        drain();
        check("t3_count", 48'(got.size()), 48'd3);
        check("t3_second", got_at(1), {24'h0A0B0C, 24'h0D0E0F});
        check("t3_third", got_at(2), {24'hC0FFEE, 24'hBADF00});

        // Disable in the middle of a right slot, then resynchronize.
        got.delete();
        start();
        send_frame({24'h135790, 24'h2468AC});
        send_slot(1'b0, 24'hDEAD00, 32);
        send_slot(1'b1, 24'hBEEF00, 10);
        check("t4_valid_before", {47'd0, valid_out}, 48'd1);
        enable_in = 1'b0;
        @(negedge clk);
        check("t4_flushed", {47'd0, valid_out}, 48'd0);
        repeat (2) @(negedge clk);
        enable_in = 1'b1;
        send_slot(1'b1, 24'h000000, 22);
        send_frame({24'h600DF0, 24'h0CAFE1});
        send_edge(1'b0, 1'b0);
        drain();
        check("t4_count", 48'(got.size()), 48'd1);
        check("t4_pair", got_at(0), {24'h600DF0, 24'h0CAFE1});

        // Short left slot.
        got.delete();
        start();
`ifdef I2S_RECEIVER_FRAMECHK_EN
        send_slot(1'b0, 24'h999999, 30);
        send_slot(1'b1, 24'h666666, 32);
        send_frame({24'h123456, 24'hABCDEF});
        send_edge(1'b0, 1'b0);
        check("t5_frame_err", {47'd0, frame_err_out}, 48'd1);
        drain();
        check("t5_count", 48'(got.size()), 48'd1);
        check("t5_pair", got_at(0), {24'h123456, 24'hABCDEF});
        clr_in = 1'b1;
        @(negedge clk);
        clr_in = 1'b0;
        check("t5_frame_err_clr", {47'd0, frame_err_out}, 48'd0);
`else
        send_slot(1'b0, 24'h123456, 20);
        send_slot(1'b1, 24'hABCDEF, 32);
        send_edge(1'b0, 1'b0);
        drain();
        check("t5_count", 48'(got.size()), 48'd1);
        check("t5_short_pair", got_at(0), {24'h123440, 24'hABCDEF});
        check("t5_frame_err", {47'd0, frame_err_out}, 48'd0);
`endif

        // Reset in the middle of a frame.
        got.delete();
        start();
        send_frame({24'h777777, 24'h888888});
        send_slot(1'b0, 24'h0F0F0F, 10);
        check("t6_valid_before", {47'd0, valid_out}, 48'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_valid", {47'd0, valid_out}, 48'd0);
        check("t6_rst_audio", {audio0_out, audio1_out}, 48'd0);
        send_slot(1'b1, 24'h000000, 32);
        send_frame({24'h314159, 24'h265358});
        send_edge(1'b0, 1'b0);
        drain();
        check("t6_count", 48'(got.size()), 48'd1);
        check("t6_pair", got_at(0), {24'h314159, 24'h265358});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
